exec: RTL and testbench

- Execute stage of the CPU pipeline, directly downstream of the operand-read stage.
- Consumes the registered operands (src_a/src_b), ALU controls, shift offset and memory controls that stage produces.
- Computes the ALU result, or performs a load/store through a req/ack memory port.
- Drives exe_out/exe_dst_reg/exe_en, which feed writeback and the read stage's forwarding mux. Asserts stall while a memory access is outstanding.

---
 rtl/exec_pkg.sv | 26 ++
 rtl/exec_alu.sv | 47 ++++
 rtl/exec.sv | 163 ++++++++++++++++
 tb/tb_exec.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: shared types and constants for the execute stage.
//   alu_op_e     - ALU operation select encoding (values 8..31 are reserved)
//   exec_state_e - execute-stage control state
//   W / AW       - datapath and memory address widths
package exec_pkg;

   localparam int W  = 16;
   localparam int AW = 32;

   typedef enum logic [4:0] {
      LOGIC = 5'd0,
      ADD   = 5'd1,
      SUB   = 5'd2,
      SHL   = 5'd3,
      SHR   = 5'd4,
      SAR   = 5'd5,
      ROL   = 5'd6,
      PASSB = 5'd7
   } alu_op_e;

   typedef enum logic {
      IDLE     = 1'b0,
      MEM_WAIT = 1'b1
   } exec_state_e;

endpackage

// File: rtl/exec_alu.sv
// exec_alu: purely combinational ALU of the execute stage.
//   a, b        - gated operands
//   truth_table - bitwise function for LOGIC, indexed by {a[i], b[i]}
//   alu_op      - operation select (reserved encodings give zero)
//   sh_off      - shift / rotate amount
//   result      - operation result
module exec_alu #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [3:0]   truth_table,
   input  logic [4:0]   alu_op,
   input  logic [3:0]   sh_off,
   output logic [W-1:0] result
);
   import exec_pkg::*;

   logic [W-1:0]   result_s;
   logic [2*W-1:0] rot_s;

   // Rotating a doubled copy leaves the rotated word in the upper half.
   assign rot_s = {a, a} << sh_off;

   // Operation decode.
   always_comb begin
      result_s = {W{1'b0}};
      case (alu_op)
         LOGIC: begin
            for (int i = 0; i < W; i++) begin
               result_s[i] = truth_table[{a[i], b[i]}];
            end
         end
         ADD:     result_s = a + b;
         SUB:     result_s = a - b;
         SHL:     result_s = a << sh_off;
         SHR:     result_s = a >> sh_off;
         SAR:     result_s = $unsigned($signed(a) >>> sh_off);
         ROL:     result_s = rot_s[2*W-1:W];
         PASSB:   result_s = b;
         default: result_s = {W{1'b0}};
      endcase
   end

   assign result = result_s;

endmodule

// File: rtl/exec.sv
// exec: execute stage. Computes an ALU result in one cycle or runs a single
// load/store over a req/ack memory port, stalling upstream while it waits.
//   cpu_clk, cpu_rst            - clock, synchronous active-high reset
//   src_a/_en, src_b/_en        - operands and their enables (disabled = 0)
//   i_dst, i_alu_en, i_truth_table, i_alu_op, sh_off - ALU instruction
//   i_mem_en, i_mem_write, mem_addr                  - memory instruction
//   mem_req/we/addr_o/wdata, mem_ack, mem_rdata      - memory port
//   stall                       - upstream must hold its outputs
//   exe_out, exe_dst_reg, exe_en - result to writeback / forwarding
module exec #(
   parameter int W  = 16,
   parameter int AW = 32
) (
   input  logic          cpu_clk,
   input  logic          cpu_rst,
   input  logic          src_a_en,
   input  logic [W-1:0]  src_a,
   input  logic          src_b_en,
   input  logic [W-1:0]  src_b,
   input  logic [3:0]    i_dst,
   input  logic          i_alu_en,
   input  logic [3:0]    i_truth_table,
   input  logic [4:0]    i_alu_op,
   input  logic [3:0]    sh_off,
   input  logic          i_mem_en,
   input  logic          i_mem_write,
   input  logic [AW-1:0] mem_addr,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr_o,
   output logic [W-1:0]  mem_wdata,
   input  logic          mem_ack,
   input  logic [W-1:0]  mem_rdata,
   output logic          stall,
   output logic [W-1:0]  exe_out,
   output logic [3:0]    exe_dst_reg,
   output logic          exe_en
);
   import exec_pkg::*;

   logic [W-1:0]  op_a_s;
   logic [W-1:0]  op_b_s;
   logic [W-1:0]  alu_res_s;

   exec_state_e   state_q, state_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [W-1:0]  mem_wdata_q, mem_wdata_d;
   logic [W-1:0]  exe_out_q, exe_out_d;
   logic [3:0]    exe_dst_q, exe_dst_d;
   logic          exe_en_q, exe_en_d;
   logic [3:0]    pend_dst_q, pend_dst_d;
   logic          pend_load_q, pend_load_d;

   assign op_a_s = src_a_en ? src_a : {W{1'b0}};
   assign op_b_s = src_b_en ? src_b : {W{1'b0}};

   exec_alu #(.W(W)) u_alu (
      .a           (op_a_s),
      .b           (op_b_s),
      .truth_table (i_truth_table),
      .alu_op      (i_alu_op),
      .sh_off      (sh_off),
      .result      (alu_res_s)
   );

   // Next-state and output-register logic; exe_en is a pulse by default.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      exe_out_d   = exe_out_q;
      exe_dst_d   = exe_dst_q;
      exe_en_d    = 1'b0;
      pend_dst_d  = pend_dst_q;
      pend_load_d = pend_load_q;
      case (state_q)
         IDLE: begin
            // A memory op wins over a simultaneous ALU op, which is dropped.
            if (i_mem_en) begin
               state_d     = MEM_WAIT;
               mem_req_d   = 1'b1;
               mem_we_d    = i_mem_write;
               mem_addr_d  = mem_addr;
               mem_wdata_d = op_a_s;
               pend_dst_d  = i_dst;
               pend_load_d = ~i_mem_write;
            end else if (i_alu_en) begin
               exe_out_d = alu_res_s;
               exe_dst_d = i_dst;
               exe_en_d  = 1'b1;
            end else begin
               exe_en_d = 1'b0;
            end
         end
         MEM_WAIT: begin
            // Inputs are ignored here; the port is held until ack.
            if (mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (pend_load_q) begin
                  exe_out_d = mem_rdata;
                  exe_dst_d = pend_dst_q;
                  exe_en_d  = 1'b1;
               end else begin
                  exe_en_d = 1'b0;
               end
            end else begin
               state_d = MEM_WAIT;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {AW{1'b0}};
         mem_wdata_q <= {W{1'b0}};
         exe_out_q   <= {W{1'b0}};
         exe_dst_q   <= 4'd0;
         exe_en_q    <= 1'b0;
         pend_dst_q  <= 4'd0;
         pend_load_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         exe_out_q   <= exe_out_d;
         exe_dst_q   <= exe_dst_d;
         exe_en_q    <= exe_en_d;
         pend_dst_q  <= pend_dst_d;
         pend_load_q <= pend_load_d;
      end
   end

   // Combinational so upstream can advance in the ack cycle; forced low
   // while reset is applied.
   assign stall = (state_q == MEM_WAIT) & ~mem_ack & ~cpu_rst;

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign exe_out     = exe_out_q;
   assign exe_dst_reg = exe_dst_q;
   assign exe_en      = exe_en_q;

endmodule

// File: tb/tb_exec.sv
module tb_exec;

   logic        cpu_clk;
   logic        cpu_rst;
   logic        src_a_en, src_b_en;
   logic [15:0] src_a, src_b;
   logic [3:0]  i_dst;
   logic        i_alu_en;
   logic [3:0]  i_truth_table;
   logic [4:0]  i_alu_op;
   logic [3:0]  sh_off;
   logic        i_mem_en, i_mem_write;
   logic [31:0] mem_addr;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr_o;
   logic [15:0] mem_wdata;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        stall;
   logic [15:0] exe_out;
   logic [3:0]  exe_dst_reg;
   logic        exe_en;

   exec dut (
      .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
      .src_a_en(src_a_en), .src_a(src_a), .src_b_en(src_b_en), .src_b(src_b),
      .i_dst(i_dst), .i_alu_en(i_alu_en), .i_truth_table(i_truth_table),
      .i_alu_op(i_alu_op), .sh_off(sh_off),
      .i_mem_en(i_mem_en), .i_mem_write(i_mem_write), .mem_addr(mem_addr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_o(mem_addr_o),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .stall(stall), .exe_out(exe_out), .exe_dst_reg(exe_dst_reg), .exe_en(exe_en)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: one outstanding memory transaction at most, kept in a queue.
   typedef struct {
      logic        we;
      logic [3:0]  dst;
   } mem_txn_t;
   mem_txn_t    pend_q[$];
   logic [31:0] m_addr  = 32'h0;
   logic [15:0] m_wdata = 16'h0;
   logic [15:0] m_out   = 16'h0;
   logic [3:0]  m_dst   = 4'h0;
   logic        m_en    = 1'b0;
   logic        stall_seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [15:0] alu_ref(input int op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [3:0] tt,
                                           input int sh);
      int ai, bi, p, sa, r;
      ai = int'(a);
      bi = int'(b);
      p  = 1 << sh;
      case (op)
         0: r = int'((tt[3] ? (a & b) : 16'h0) | (tt[2] ? (a & ~b) : 16'h0) |
                     (tt[1] ? (~a & b) : 16'h0) | (tt[0] ? (~a & ~b) : 16'h0));
         1: r = (ai + bi) % 65536;
         2: r = (ai - bi + 65536) % 65536;
         3: r = (ai * p) % 65536;
         4: r = ai / p;
         5: begin
            sa = (ai >= 32768) ? ai - 65536 : ai;
            r  = (sa >= 0) ? sa / p : -(((-sa) + p - 1) / p);
            r  = (r + 65536) % 65536;
         end
         6: r = ((ai * p) % 65536) + ai / (65536 / p);
         7: r = bi;
         default: r = 0;
      endcase
      return r[15:0];
   endfunction

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_step();
      logic [15:0] a, b;
      mem_txn_t    t;
      a = src_a_en ? src_a : 16'h0;
      b = src_b_en ? src_b : 16'h0;
      if (cpu_rst) begin
         pend_q.delete();
         m_addr = 32'h0; m_wdata = 16'h0; m_out = 16'h0; m_dst = 4'h0; m_en = 1'b0;
      end else if (pend_q.size() != 0) begin
         m_en = 1'b0;
         if (mem_ack) begin
            t = pend_q.pop_front();
            if (!t.we) begin
               m_out = mem_rdata; m_dst = t.dst; m_en = 1'b1;
            end
         end
      end else if (i_mem_en) begin
         t.we = i_mem_write; t.dst = i_dst;
         pend_q.push_back(t);
         m_addr = mem_addr; m_wdata = a; m_en = 1'b0;
      end else if (i_alu_en) begin
         m_out = alu_ref(int'(i_alu_op), a, b, i_truth_table, int'(sh_off));
         m_dst = i_dst; m_en = 1'b1;
      end else begin
         m_en = 1'b0;
      end
   endtask

   task automatic compare_all();
      logic busy;
      busy = (pend_q.size() != 0);
      check("mem_req", {31'h0, mem_req}, {31'h0, busy});
      check("mem_we", {31'h0, mem_we}, {31'h0, busy ? pend_q[0].we : 1'b0});
      check("mem_addr_o", mem_addr_o, m_addr);
      check("mem_wdata", {16'h0, mem_wdata}, {16'h0, m_wdata});
      check("exe_en", {31'h0, exe_en}, {31'h0, m_en});
      check("exe_out", {16'h0, exe_out}, {16'h0, m_out});
      check("exe_dst_reg", {28'h0, exe_dst_reg}, {28'h0, m_dst});
   endtask

   // One clock: check combinational stall, take the edge, check registered outputs.
   task automatic cycle();
      logic exp_stall;
      #1;
      exp_stall = (pend_q.size() != 0) & ~mem_ack & ~cpu_rst;
      stall_seen = stall;
      check("stall", {31'h0, stall}, {31'h0, exp_stall});
      @(posedge cpu_clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      src_a_en = 1'b1; src_b_en = 1'b1; src_a = 16'h0; src_b = 16'h0;
      i_dst = 4'h0; i_alu_en = 1'b0; i_truth_table = 4'h0; i_alu_op = 5'd0;
      sh_off = 4'h0; i_mem_en = 1'b0; i_mem_write = 1'b0; mem_addr = 32'h0;
      mem_ack = 1'b0; mem_rdata = 16'h0;
   endtask

   task automatic alu_op(input int op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] tt, input logic [3:0] sh, input logic [3:0] dst);
      idle_inputs();
      i_alu_en = 1'b1; i_alu_op = op[4:0]; src_a = a; src_b = b;
      i_truth_table = tt; sh_off = sh; i_dst = dst;
   endtask

   initial begin
      idle_inputs();
      cpu_rst = 1'b1;
      @(posedge cpu_clk); #1;
      cycle();
      check("reset exe_out", {16'h0, exe_out}, 32'h0);
      check("reset exe_en", {31'h0, exe_en}, 32'h0);
      check("reset mem_req", {31'h0, mem_req}, 32'h0);
      check("reset stall", {31'h0, stall_seen}, 32'h0);
      cpu_rst = 1'b0;

      // LOGIC XOR then idle
      alu_op(0, 16'h00FF, 16'h0F0F, 4'b0110, 4'h0, 4'd3);
      cycle();
      check("xor out", {16'h0, exe_out}, 32'h0FF0);
      check("xor dst", {28'h0, exe_dst_reg}, 32'd3);
      check("xor en", {31'h0, exe_en}, 32'd1);
      idle_inputs();
      cycle();
      check("xor en pulse", {31'h0, exe_en}, 32'd0);

      alu_op(2, 16'h0001, 16'h0002, 4'h0, 4'h0, 4'd1);
      cycle();
      check("sub", {16'h0, exe_out}, 32'hFFFF);
      alu_op(1, 16'h8000, 16'h1234, 4'h0, 4'h0, 4'd2);
      src_b_en = 1'b0;
      cycle();
      check("add gated", {16'h0, exe_out}, 32'h8000);
      alu_op(3, 16'h8001, 16'h0, 4'h0, 4'd4, 4'd4); cycle();
      check("shl", {16'h0, exe_out}, 32'h0010);
      alu_op(4, 16'h8001, 16'h0, 4'h0, 4'd4, 4'd4); cycle();
      check("shr", {16'h0, exe_out}, 32'h0800);
      alu_op(5, 16'h8001, 16'h0, 4'h0, 4'd4, 4'd4); cycle();
      check("sar", {16'h0, exe_out}, 32'hF800);
      alu_op(6, 16'h8001, 16'h0, 4'h0, 4'd4, 4'd4); cycle();
      check("rol", {16'h0, exe_out}, 32'h0018);
      alu_op(9, 16'h8001, 16'h5555, 4'h0, 4'd4, 4'd6); cycle();
      check("reserved out", {16'h0, exe_out}, 32'h0000);
      check("reserved en", {31'h0, exe_en}, 32'd1);

      // Load, ack three cycles after req
      idle_inputs();
      i_mem_en = 1'b1; i_mem_write = 1'b0; mem_addr = 32'h0001_0004; i_dst = 4'd5;
      cycle();
      check("load req", {31'h0, mem_req}, 32'd1);
      cycle();
      check("load stall1", {31'h0, stall_seen}, 32'd1);
      cycle();
      check("load stall2", {31'h0, stall_seen}, 32'd1);
      check("load addr", mem_addr_o, 32'h0001_0004);
      mem_ack = 1'b1; mem_rdata = 16'hBEEF;
      cycle();
      check("load stall ack", {31'h0, stall_seen}, 32'd0);
      check("load out", {16'h0, exe_out}, 32'hBEEF);
      check("load dst", {28'h0, exe_dst_reg}, 32'd5);
      check("load en", {31'h0, exe_en}, 32'd1);
      check("load req drop", {31'h0, mem_req}, 32'd0);

      // Store with ack at N+1, ALU op presented alongside is dropped
      alu_op(1, 16'h1234, 16'h0001, 4'h0, 4'h0, 4'd7);
      i_mem_en = 1'b1; i_mem_write = 1'b1;
      cycle();
      check("store we", {31'h0, mem_we}, 32'd1);
      check("store wdata", {16'h0, mem_wdata}, 32'h1234);
      check("store en0", {31'h0, exe_en}, 32'd0);
      mem_ack = 1'b1;
      cycle();
      check("store en1", {31'h0, exe_en}, 32'd0);
      idle_inputs();
      cycle();
      check("store drop", {16'h0, exe_out}, 32'hBEEF);

      // Reset while waiting, then a late ack
      idle_inputs();
      i_mem_en = 1'b1; mem_addr = 32'hA5A5_0000; i_dst = 4'd9;
      cycle();
      idle_inputs();
      cpu_rst = 1'b1;
      cycle();
      check("rst wait stall", {31'h0, stall_seen}, 32'd0);
      check("rst wait req", {31'h0, mem_req}, 32'd0);
      cpu_rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h7777;
      cycle();
      check("late ack stall", {31'h0, stall_seen}, 32'd0);
      check("late ack en", {31'h0, exe_en}, 32'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 2000; n++) begin
         cpu_rst       = ($urandom_range(0, 99) == 0);
         src_a_en      = ($urandom_range(0, 7) != 0);
         src_b_en      = ($urandom_range(0, 7) != 0);
         src_a         = 16'($urandom);
         src_b         = 16'($urandom);
         i_dst         = 4'($urandom);
         i_alu_en      = ($urandom_range(0, 1) == 1);
         i_truth_table = 4'($urandom);
         i_alu_op      = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(8, 31))
                                                     : 5'($urandom_range(0, 7));
         sh_off        = 4'($urandom);
         i_mem_en      = ($urandom_range(0, 4) == 0);
         i_mem_write   = ($urandom_range(0, 1) == 1);
         mem_addr      = $urandom;
         mem_ack       = ($urandom_range(0, 2) == 0);
         mem_rdata     = 16'($urandom);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
